// File: rtl/player_control_pkg.sv
// rtl/player_control_pkg.sv - arena walls, spawn values, state encoding and clamp helper shared by the game blocks
package player_control_pkg;

  localparam logic [9:0] X_MIN   = 10'd15;
  localparam logic [9:0] X_MAX   = 10'd626;
  localparam logic [9:0] Y_MIN   = 10'd15;
  localparam logic [9:0] Y_MAX   = 10'd466;
  localparam logic [9:0] START_X = 10'd320;
  localparam logic [9:0] START_Y = 10'd240;
  localparam logic [9:0] R_INIT  = 10'd10;
  localparam logic [9:0] R_MAX   = 10'd40;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_HOLD = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  // Signed compare so a step past a wall near zero can never wrap.
  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                            input logic [9:0] lo,
                                            input logic [9:0] hi);
    logic signed [10:0] s_lo;
    logic signed [10:0] s_hi;
    s_lo = $signed({1'b0, lo});
    s_hi = $signed({1'b0, hi});
    if (v < s_lo) return lo;
    if (v > s_hi) return hi;
    return v[9:0];
  endfunction

endpackage

// File: rtl/player_tick_gen.sv
// rtl/player_tick_gen.sv - move-tick strobe, one cycle every TICK_DIV enabled cycles
module player_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/player_control.sv
// rtl/player_control.sv - player blob: button movement, food growth and score, enemy hits and lives
module player_control
  import player_control_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int STEP     = 2,
  parameter int R_GROW   = 2,
  parameter int LIVES    = 3,
  parameter int INVULN   = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_gamemenu,
  input  logic       i_gamerun,
  input  logic       i_gamepause,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_collide_food,
  input  logic [3:0] i_collide_enemy,
  output logic [9:0] o_aX,
  output logic [9:0] o_aY,
  output logic [9:0] o_aR,
  output logic [7:0] o_score,
  output logic [1:0] o_lives,
  output logic       o_game_over
);
  localparam int IW = $clog2(INVULN + 1);
  localparam logic [IW-1:0]      IMM_LAST = IW'(INVULN - 1);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);
  localparam logic [9:0]         GROW_V   = 10'(R_GROW);
  localparam logic [1:0]         LIVES_V  = 2'(LIVES);

  state_t r_state, r_ret, w_next_state, w_next_ret;

  logic [9:0]    r_x, r_y, r_r;
  logic [7:0]    r_score;
  logic [1:0]    r_lives;
  logic [IW-1:0] r_imm;
  logic [4:0]    r_sync1, r_sync2, r_prev, r_evt;

  logic [2:0]         w_mode;
  logic               w_menu, w_run, w_pause;
  logic               w_en, w_tick, w_active;
  logic               w_food_evt, w_enemy_evt, w_hit, w_imm_done;
  logic [1:0]         w_lives_dec;
  logic signed [10:0] w_x_mv, w_y_mv;
  logic [9:0]         w_x_cl, w_y_cl, w_r_grow;

  // Bit 0 is food, bits 4:1 the enemies; the edge is registered so an event lands 4 clk after a rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_evt   <= '0;
    end else begin
      r_sync1 <= {i_collide_enemy, i_collide_food};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_evt   <= r_sync2 & ~r_prev;
    end
  end

  assign w_food_evt  = r_evt[0];
  assign w_enemy_evt = |r_evt[4:1];

  assign w_mode  = {i_gamemenu, i_gamerun, i_gamepause};
  assign w_menu  = (w_mode == 3'b100);
  assign w_run   = (w_mode == 3'b010);
  assign w_pause = (w_mode == 3'b001);

  assign w_en        = (r_state == ST_PLAY) || (r_state == ST_HIT);
  assign w_active    = w_en && w_run;
  assign w_hit       = w_active && (r_state == ST_PLAY) && w_enemy_evt;
  assign w_imm_done  = w_active && (r_state == ST_HIT) && w_tick && (r_imm == IMM_LAST);
  assign w_lives_dec = r_lives - 2'd1;

  player_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (w_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ret   <= ST_PLAY;
    end else begin
      r_state <= w_next_state;
      r_ret   <= w_next_ret;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_ret   = r_ret;
    case (r_state)
      ST_IDLE: if (w_run) w_next_state = ST_PLAY;
      ST_PLAY, ST_HIT: begin
        if (w_menu) begin
          w_next_state = ST_IDLE;
        end else if (w_pause) begin
          w_next_state = ST_HOLD;
          w_next_ret   = r_state;
        end else if (w_hit) begin
          w_next_state = (w_lives_dec == 2'd0) ? ST_OVER : ST_HIT;
        end else if (w_imm_done) begin
          w_next_state = ST_PLAY;
        end
      end
      ST_HOLD: begin
        if (w_run)       w_next_state = r_ret;
        else if (w_menu) w_next_state = ST_IDLE;
      end
      ST_OVER: if (w_menu) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Opposite buttons cancel; the clamp runs every active cycle so a grown radius is re-fitted next cycle.
  always_comb begin
    w_x_mv = $signed({1'b0, r_x});
    w_y_mv = $signed({1'b0, r_y});
    if (w_tick) begin
      if (i_btn_right && !i_btn_left) w_x_mv = w_x_mv + STEP_S;
      if (i_btn_left && !i_btn_right) w_x_mv = w_x_mv - STEP_S;
      if (i_btn_down && !i_btn_up)    w_y_mv = w_y_mv + STEP_S;
      if (i_btn_up && !i_btn_down)    w_y_mv = w_y_mv - STEP_S;
    end
  end

  assign w_x_cl   = clamp_axis(w_x_mv, X_MIN + r_r, X_MAX - r_r);
  assign w_y_cl   = clamp_axis(w_y_mv, Y_MIN + r_r, Y_MAX - r_r);
  assign w_r_grow = (r_r + GROW_V > R_MAX) ? R_MAX : r_r + GROW_V;

  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state == ST_IDLE)) begin
      r_x     <= START_X;
      r_y     <= START_Y;
      r_r     <= R_INIT;
      r_score <= '0;
      r_lives <= LIVES_V;
      r_imm   <= '0;
    end else if (w_active) begin
      r_x <= w_x_cl;
      r_y <= w_y_cl;
      if (w_food_evt) begin
        if (r_score != 8'hFF) r_score <= r_score + 8'd1;
        r_r <= w_r_grow;
      end
      // The enemy reset of position and radius overrides any same-cycle growth.
      if (w_hit) begin
        r_lives <= w_lives_dec;
        r_r     <= R_INIT;
        r_x     <= START_X;
        r_y     <= START_Y;
        r_imm   <= '0;
      end else if ((r_state == ST_HIT) && w_tick) begin
        r_imm <= r_imm + IW'(1);
      end
    end
  end

  assign o_aX        = r_x;
  assign o_aY        = r_y;
  assign o_aR        = r_r;
  assign o_score     = r_score;
  assign o_lives     = r_lives;
  assign o_game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_player_control.sv
// tb/tb_player_control.sv - directed and randomized bench for player_control against a game-level model
module tb_player_control;
  localparam int TD  = 4;
  localparam int INV = 3;

  localparam int M_MENU   = 0;
  localparam int M_PLAY   = 1;
  localparam int M_IMMUNE = 2;
  localparam int M_PAUSED = 3;
  localparam int M_OVER   = 4;

  logic       clk = 1'b0;
  logic       rst, menu, run, pause, up, down, left, right, food;
  logic [3:0] enemy;
  logic [9:0] ax, ay, ar;
  logic [7:0] score;
  logic [1:0] lives;
  logic       over;

  int checks = 0;
  int errors = 0;

  int m_x = 0, m_y = 0, m_r = 0, m_score = 0, m_lives = 0;
  int m_mode = 0, m_ret = 0, m_imm = 0, m_cnt = 0;
  int fh[4];
  int eh[4][4];

  always #5 clk = ~clk;

  player_control #(.TICK_DIV(TD), .INVULN(INV)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_gamemenu      (menu),
    .i_gamerun       (run),
    .i_gamepause     (pause),
    .i_btn_up        (up),
    .i_btn_down      (down),
    .i_btn_left      (left),
    .i_btn_right     (right),
    .i_collide_food  (food),
    .i_collide_enemy (enemy),
    .o_aX            (ax),
    .o_aY            (ay),
    .o_aR            (ar),
    .o_score         (score),
    .o_lives         (lives),
    .o_game_over     (over)
  );

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_spawn();
    m_x = 320; m_y = 240; m_r = 10; m_score = 0; m_lives = 3; m_imm = 0;
  endtask

  // Game-level view of one clock: collide rises are seen three samples later, ticks every TD playing cycles.
  task automatic model_step();
    bit fev, eev, tick, en, is_menu, is_run, is_pause;
    int nx, ny, nr, st0;
    if (rst) begin
      model_spawn();
      m_mode = M_MENU; m_ret = M_PLAY; m_cnt = 0;
      for (int a = 0; a < 4; a++) begin
        fh[a] = 0;
        for (int l = 0; l < 4; l++) eh[l][a] = 0;
      end
      return;
    end
    fev = (fh[2] != 0) && (fh[3] == 0);
    eev = 0;
    for (int l = 0; l < 4; l++) eev |= (eh[l][2] != 0) && (eh[l][3] == 0);
    for (int a = 3; a > 0; a--) begin
      fh[a] = fh[a-1];
      for (int l = 0; l < 4; l++) eh[l][a] = eh[l][a-1];
    end
    fh[0] = int'(food);
    for (int l = 0; l < 4; l++) eh[l][0] = int'(enemy[l]);

    is_menu  = {menu, run, pause} == 3'b100;
    is_run   = {menu, run, pause} == 3'b010;
    is_pause = {menu, run, pause} == 3'b001;
    en   = (m_mode == M_PLAY) || (m_mode == M_IMMUNE);
    tick = en && (m_cnt == TD - 1);
    m_cnt = en ? (m_cnt + 1) % TD : 0;
    st0 = m_mode;

    case (st0)
      M_MENU: begin
        model_spawn();
        if (is_run) m_mode = M_PLAY;
      end
      M_PLAY, M_IMMUNE: begin
        if (is_menu) m_mode = M_MENU;
        else if (is_pause) begin m_ret = st0; m_mode = M_PAUSED; end
        else if (is_run) begin
          nx = m_x; ny = m_y;
          if (tick) begin
            nx += 2 * (int'(right) - int'(left));
            ny += 2 * (int'(down) - int'(up));
          end
          nx = clampi(nx, 15 + m_r, 626 - m_r);
          ny = clampi(ny, 15 + m_r, 466 - m_r);
          nr = m_r;
          if (fev) begin
            m_score = (m_score < 255) ? m_score + 1 : 255;
            nr = (m_r + 2 > 40) ? 40 : m_r + 2;
          end
          if (eev && st0 == M_PLAY) begin
            m_lives--;
            nr = 10; nx = 320; ny = 240; m_imm = 0;
            m_mode = (m_lives == 0) ? M_OVER : M_IMMUNE;
          end else if (st0 == M_IMMUNE && tick) begin
            m_imm++;
            if (m_imm == INV) m_mode = M_PLAY;
          end
          m_x = nx; m_y = ny; m_r = nr;
        end
      end
      M_PAUSED: begin
        if (is_run) m_mode = m_ret;
        else if (is_menu) m_mode = M_MENU;
      end
      M_OVER: if (is_menu) m_mode = M_MENU;
      default: m_mode = M_MENU;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      chk("model_aX", 32'(ax), m_x);
      chk("model_aY", 32'(ay), m_y);
      chk("model_aR", 32'(ar), m_r);
      chk("model_score", 32'(score), m_score);
      chk("model_lives", 32'(lives), m_lives);
      chk("model_game_over", 32'(over), (m_mode == M_OVER) ? 1 : 0);
    end
  endtask

  task automatic chk_spawn(input string tag);
    chk({tag, "_aX"}, 32'(ax), 320);
    chk({tag, "_aY"}, 32'(ay), 240);
    chk({tag, "_aR"}, 32'(ar), 10);
    chk({tag, "_score"}, 32'(score), 0);
    chk({tag, "_lives"}, 32'(lives), 3);
    chk({tag, "_game_over"}, 32'(over), 0);
  endtask

  initial begin
    rst = 1; menu = 1; run = 0; pause = 0;
    up = 0; down = 0; left = 0; right = 0; food = 0; enemy = 4'd0;
    step(3);
    chk_spawn("reset");
    rst = 0;
    step(2);

    menu = 0; run = 1; right = 1;
    step(41);
    right = 0;
    chk("walk_aX", 32'(ax), 340);
    chk("walk_aY", 32'(ay), 240);
    chk("walk_aR", 32'(ar), 10);
    chk("walk_lives", 32'(lives), 3);

    for (int k = 0; k < 40; k++) begin
      {up, down, left, right} = 4'($urandom);
      step(1 + $urandom_range(0, 12));
    end
    {up, down, left, right} = 4'd0;

    right = 1;
    step(1250);
    chk("right_wall_aX", 32'(ax), 616);
    right = 0; left = 1;
    step(1250);
    chk("left_wall_aX", 32'(ax), 25);
    left = 0;

    food = 1; step(50); food = 0; step(6);
    chk("food1_score", 32'(score), 1);
    chk("food1_aR", 32'(ar), 12);
    for (int k = 0; k < 16; k++) begin
      food = 1; step($urandom_range(1, 40));
      food = 0; step($urandom_range(1, 8));
    end
    step(6);
    chk("food17_score", 32'(score), 17);
    chk("food17_aR", 32'(ar), 40);

    enemy[2] = 1; step(5);
    chk("hit1_lives", 32'(lives), 2);
    chk("hit1_aR", 32'(ar), 10);
    chk("hit1_aX", 32'(ax), 320);
    chk("hit1_aY", 32'(ay), 240);
    enemy[2] = 0; enemy[0] = 1; step(3);
    enemy[0] = 0; step(2);
    chk("immune_lives", 32'(lives), 2);
    step(20);
    enemy[1] = 1; step(5);
    chk("hit2_lives", 32'(lives), 1);
    enemy[1] = 0;

    step(1);
    run = 0; pause = 1; step(2);
    up = 1; left = 1; food = 1; enemy[3] = 1; step(40);
    food = 0; enemy = 4'd0; step(38);
    chk("pause_aX", 32'(ax), 320);
    chk("pause_aY", 32'(ay), 240);
    chk("pause_score", 32'(score), 17);
    chk("pause_lives", 32'(lives), 1);
    up = 0; left = 0;
    pause = 0; run = 1; enemy[0] = 1; step(2);
    enemy[0] = 0; step(6);
    chk("resume_immune_lives", 32'(lives), 1);
    step(20);

    enemy = 4'b1001; step(5);
    chk("hit3_lives", 32'(lives), 0);
    chk("hit3_game_over", 32'(over), 1);
    enemy = 4'd0;
    right = 1; down = 1; food = 1; step(30);
    food = 0; step(10);
    chk("over_aX", 32'(ax), 320);
    chk("over_aY", 32'(ay), 240);
    chk("over_score", 32'(score), 17);
    chk("over_game_over", 32'(over), 1);
    right = 0; down = 0;
    run = 0; menu = 1; step(2);
    chk_spawn("menu");

    menu = 0; run = 1; step(2);
    for (int k = 0; k < 260; k++) begin
      food = 1; step(2);
      food = 0; step(2);
    end
    step(6);
    chk("sat_score", 32'(score), 255);
    chk("sat_aR", 32'(ar), 40);

    right = 1; step(6);
    rst = 1; step(1);
    chk_spawn("midtick_rst");
    rst = 0; right = 0;
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
